seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. It shares one combinational BCD-to-segment decoder among NUM_DIGITS digits: it presents one BCD nibble at a time, registers the returned segment pattern and drives a one-hot digit select. A blanking gap between digits suppresses ghosting. A shadow/active register pair guarantees tear-free frame updates. It sits between the system's BCD value producer and the display pins.

---
 rtl/seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one digit per slot through a shared BCD decoder,
// with a dark gap at each slot start and a shadow register for tear-free updates.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lzb,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              dec_in,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   active;
  logic [DW-1:0]   shadow;
  logic            pending;

  logic [3:0]            cur_nib;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic                  blank_dig;
  logic                  slot_end;
  logic                  frame_wrap;

  // Current nibble, its one-hot select, and whether every digit from idx upward is zero.
  always_comb begin
    cur_nib    = 4'd0;
    upper_zero = 1'b1;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib       = active[4*i +: 4];
        sel_onehot[i] = 1'b1;
      end
      if (IW'(i) >= idx && active[4*i +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign dec_in     = cur_nib;
  assign blank_dig  = (cur_nib > 4'd9) || (lzb && (idx != '0) && upper_zero);
  assign slot_end   = (cnt == CNT_MAX);
  assign frame_wrap = slot_end && (idx == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      seg_out    <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt        <= '0;
          idx        <= '0;
          seg_out    <= '0;
          dig_sel    <= '0;
          frame_done <= 1'b0;
          // A direct load wins over a deferred shadow commit on scan entry.
          if (load) begin
            active  <= load_data;
            pending <= 1'b0;
          end else if (enable && pending) begin
            active  <= shadow;
            pending <= 1'b0;
          end
          if (enable) begin
            state <= SCAN;
          end
        end

        SCAN: begin
          if (!enable) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            seg_out    <= '0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
          end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
              idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
            if (cnt < CNT_BLANK) begin
              dig_sel <= '0;
              seg_out <= '0;
            end else begin
              dig_sel <= sel_onehot;
              seg_out <= blank_dig ? 7'd0 : seg_in;
            end
            frame_done <= frame_wrap;
          end

          // Commit only at a frame boundary so a frame never mixes old and new digits.
          if (enable && frame_wrap) begin
            pending <= 1'b0;
            if (load) begin
              active <= load_data;
              shadow <= load_data;
            end else if (pending) begin
              active <= shadow;
            end
          end else if (load) begin
            shadow  <= load_data;
            pending <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a behavioural BCD decoder on the shared decoder port.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          lzb;
  logic          load;
  logic [15:0]   load_data;
  logic [3:0]    dec_in;
  logic [6:0]    seg_in;
  logic [6:0]    seg_out;
  logic [ND-1:0] dig_sel;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lzb(lzb), .load(load),
    .load_data(load_data), .dec_in(dec_in), .seg_in(seg_in), .seg_out(seg_out),
    .dig_sel(dig_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] bcd2seg(input logic [3:0] d);
    case (d)
      4'd0: bcd2seg = 7'b1111110;
      4'd1: bcd2seg = 7'b0110000;
      4'd2: bcd2seg = 7'b1101101;
      4'd3: bcd2seg = 7'b1111001;
      4'd4: bcd2seg = 7'b0110011;
      4'd5: bcd2seg = 7'b1011011;
      4'd6: bcd2seg = 7'b1011111;
      4'd7: bcd2seg = 7'b1110000;
      4'd8: bcd2seg = 7'b1111111;
      4'd9: bcd2seg = 7'b1110011;
      default: bcd2seg = 7'b1001111;
    endcase
  endfunction

  assign seg_in = bcd2seg(dec_in);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs visible one cycle after scan cycle c of a frame (c<0: not yet scanning).
  task automatic expect_at(input int c, input logic [15:0] v, input logic lz,
                           output logic [ND-1:0] ds, output logic [6:0] sg, output logic fd);
    int d;
    int p;
    logic [3:0] nib;
    logic blank;
    ds = '0;
    sg = '0;
    fd = 1'b0;
    if (c >= 0) begin
      d     = (c % FRAME) / DIV;
      p     = c % DIV;
      fd    = ((c % FRAME) == FRAME - 1);
      nib   = v[4*d +: 4];
      blank = (nib > 4'd9) || (lz && d != 0 && (v >> (4*d)) == 16'd0);
      if (p >= BLANK) begin
        ds = ND'(1) << d;
        sg = blank ? 7'd0 : bcd2seg(nib);
      end
    end
  endtask

  // Samples n consecutive negedges; any load strobe raised before the call lasts one edge.
  task automatic run_cycles(input int first_c, input int n, input logic [15:0] v,
                            input logic lz, input string tag);
    logic [ND-1:0] eds;
    logic [6:0]    esg;
    logic          efd;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      load = 1'b0;
      expect_at(first_c + j, v, lz, eds, esg, efd);
      chk($sformatf("%s c=%0d dig_sel", tag, first_c + j), 16'(dig_sel), 16'(eds));
      chk($sformatf("%s c=%0d seg_out", tag, first_c + j), 16'(seg_out), 16'(esg));
      chk($sformatf("%s c=%0d frame_done", tag, first_c + j), 16'(frame_done), 16'(efd));
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " dig_sel"}, 16'(dig_sel), 16'd0);
    chk({tag, " seg_out"}, 16'(seg_out), 16'd0);
    chk({tag, " frame_done"}, 16'(frame_done), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; lzb = 1'b0; load = 1'b0; load_data = 16'h0000;

    // Reset state
    @(negedge clk);
    chk_dark("reset");
    chk("reset dec_in", 16'(dec_in), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Free-running scan of all zeros, two frames
    enable = 1'b1;
    run_cycles(-1, FRAME + 1, 16'h0000, 1'b0, "zeros_start");
    run_cycles(0, FRAME, 16'h0000, 1'b0, "zeros_frame2");

    // Direct load while idle
    enable = 1'b0;
    @(negedge clk);
    chk_dark("idle");
    load = 1'b1; load_data = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    chk("idle_load dec_in", 16'(dec_in), 16'h0004);
    enable = 1'b1;
    run_cycles(-1, FRAME + 1, 16'h1234, 1'b0, "v1234");

    // Mid-frame load during digit 1: current frame unchanged, next frame new
    run_cycles(0, 12, 16'h1234, 1'b0, "v1234_pre");
    load = 1'b1; load_data = 16'h9999;
    run_cycles(12, FRAME - 12, 16'h1234, 1'b0, "v1234_post");
    run_cycles(0, FRAME, 16'h9999, 1'b0, "v9999");

    // Leading-zero blanking
    lzb = 1'b1;
    load = 1'b1; load_data = 16'h0050;
    run_cycles(0, FRAME, 16'h9999, 1'b1, "v9999_lzb");
    run_cycles(0, FRAME, 16'h0050, 1'b1, "lzb_0050");
    load = 1'b1; load_data = 16'h0000;
    run_cycles(0, FRAME, 16'h0050, 1'b1, "lzb_0050b");
    run_cycles(0, FRAME, 16'h0000, 1'b1, "lzb_0000");

    // Non-BCD nibble plus last-load-wins within one frame
    lzb = 1'b0;
    load = 1'b1; load_data = 16'h1111;
    run_cycles(0, 10, 16'h0000, 1'b0, "nolzb_a");
    load = 1'b1; load_data = 16'h5A31;
    run_cycles(10, FRAME - 10, 16'h0000, 1'b0, "nolzb_b");
    run_cycles(0, FRAME, 16'h5A31, 1'b0, "v5A31");

    // Enable dropped mid-slot
    run_cycles(0, 13, 16'h5A31, 1'b0, "pre_disable");
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_dark($sformatf("disabled k=%0d", k));
    end
    enable = 1'b1;
    run_cycles(-1, FRAME + 1, 16'h5A31, 1'b0, "reenable");

    // Reset asserted mid-slot clears outputs without a clock edge
    run_cycles(0, 13, 16'h5A31, 1'b0, "pre_reset");
    rst_n = 1'b0;
    #1;
    chk_dark("async_reset");
    chk("async_reset dec_in", 16'(dec_in), 16'd0);
    repeat (3) @(negedge clk);
    chk_dark("held_reset");
    rst_n = 1'b1;
    run_cycles(-1, FRAME + 1, 16'h0000, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
